// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Default configuration, matching the FIFO this arbiter normally feeds
  localparam int DEF_DSIZE     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;

  // Width of a requester index (at least one bit)
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first asserted
// request searching upward from last+1, wrapping at NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] winner_s;
  int            idx_v;

  // Scan from the farthest candidate to the nearest so the nearest valid
  // requester after 'last' is the final (winning) assignment.
  always_comb begin
    winner_s = {IW{1'b0}};
    idx_v    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_v    = (int'(last) + k) % NREQ;
      winner_s = req[idx_v] ? IW'(idx_v) : winner_s;
    end
  end

  assign winner = winner_s;
  assign any    = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one async-FIFO write port
// among NREQ producers in the write-clock domain.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW       = id_width(NREQ),
  localparam int CW       = $clog2(MAX_BURST) + 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  arb_state_t    state_r, state_s;
  logic [IW-1:0] owner_r, owner_s;
  logic [IW-1:0] last_owner_r, last_owner_s;
  logic [CW-1:0] beat_cnt_r, beat_cnt_s;
  logic [IW-1:0] pick_s;
  logic          any_s;
  logic          owner_valid_s;
  logic          xfer_s;
  logic          last_beat_s;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req_valid),
    .last   (last_owner_r),
    .winner (pick_s),
    .any    (any_s)
  );

  assign owner_valid_s = req_valid[owner_r];
  assign xfer_s        = (state_r == GRANT) & owner_valid_s & ~wfull;
  assign last_beat_s   = (beat_cnt_r == CW'(MAX_BURST - 1));

  // State, owner, rotation pointer and beat counter registers
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_r      <= IDLE;
      owner_r      <= {IW{1'b0}};
      last_owner_r <= IW'(NREQ - 1);
      beat_cnt_r   <= {CW{1'b0}};
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
      beat_cnt_r   <= beat_cnt_s;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and decide release in GRANT
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    beat_cnt_s   = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          owner_s    = pick_s;
          beat_cnt_s = {CW{1'b0}};
          state_s    = GRANT;
        end else begin
          state_s    = IDLE;
        end
      end
      GRANT: begin
        if (!owner_valid_s) begin
          // Owner went idle: give the port back without writing
          state_s      = IDLE;
          last_owner_s = owner_r;
        end else if (xfer_s) begin
          beat_cnt_s = beat_cnt_r + CW'(1'b1);
          if (last_beat_s) begin
            state_s      = IDLE;
            last_owner_s = owner_r;
          end else begin
            state_s      = GRANT;
          end
        end else begin
          // FIFO full: hold grant and beat count
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output mux: only the owner sees ready, and only while the FIFO has room
  always_comb begin
    req_ready = {NREQ{1'b0}};
    winc      = 1'b0;
    wdata     = {DSIZE{1'b0}};
    grant_id  = {IW{1'b0}};
    busy      = 1'b0;
    case (state_r)
      GRANT: begin
        req_ready[owner_r] = ~wfull;
        winc               = xfer_s;
        wdata              = req_data[owner_r*DSIZE +: DSIZE];
        grant_id           = owner_r;
        busy               = 1'b1;
      end
      IDLE: begin
        busy = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural producers feed queued beats,
// expected FIFO writes go into a scoreboard, a monitor checks each write.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAX_BURST(4)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // 100 MHz write clock
  always #5 wclk = ~wclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  src_mem [4][16];
  int          src_len [4];
  int          src_ptr [4];
  logic [3:0]  hs;
  logic        obs_winc, obs_busy;
  logic [1:0]  obs_gid;
  logic [3:0]  obs_ready;
  logic [7:0]  obs_wdata;
  int          wcount, idles;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] dval(input int r, input int k);
    return 8'((r + 1) * 16 + k);
  endfunction

  task automatic add_beat(input int r, input logic [7:0] d);
    src_mem[r][src_len[r]] = d;
    src_len[r]++;
  endtask

  task automatic push_exp(input int r, input logic [7:0] d);
    exp_q.push_back({2'(r), d});
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
  endtask

  // Producers present the head of their queue and hold it until accepted
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (src_ptr[i] < src_len[i]);
      req_data[i*8 +: 8]  = req_valid[i] ? src_mem[i][src_ptr[i]] : 8'h00;
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < 4; i++) p = p | (src_ptr[i] < src_len[i]);
    return p;
  endfunction

  // One clock: observe mid-cycle, then advance producers after the edge
  task automatic tick();
    @(negedge wclk);
    obs_winc  = winc;
    obs_busy  = busy;
    obs_gid   = grant_id;
    obs_ready = req_ready;
    obs_wdata = wdata;
    hs        = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) src_ptr[i]++;
    drive();
  endtask

  task automatic do_reset();
    wrst  = 1'b1;
    wfull = 1'b0;
    flush();
    drive();
    #1;
    tick();
    tick();
    wrst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rand_full);
    int k = 0;
    while ((exp_q.size() != 0 || pending()) && k < budget) begin
      if (rand_full) wfull = ($urandom_range(0, 9) < 3);
      else wfull = 1'b0;
      tick();
      k++;
    end
    wfull = 1'b0;
    chk("drain_in_budget", 32'(k < budget), 32'd1);
    tick();
    tick();
    tick();
  endtask

  // Scoreboard monitor: every write must match the next expected beat
  always @(negedge wclk) begin
    if (wrst === 1'b0 && winc === 1'b1) begin
      chk("no_write_when_full", 32'(wfull), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got id %0d data %0h expected no write", grant_id, wdata);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("write_id", 32'(grant_id), 32'(e[9:8]));
        chk("write_data", 32'(wdata), 32'(e[7:0]));
      end
    end
  end

  // Hard stop if the run ever wedges
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst      = 1'b0;
    wfull     = 1'b0;
    req_valid = 4'h0;
    req_data  = 32'h0;
    flush();
    #2;
    wrst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_winc",      32'(winc),      32'd0);
    chk("rst_wdata",     32'(wdata),     32'd0);
    chk("rst_grant_id",  32'(grant_id),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    do_reset();

    // Requester 1 alone, three beats
    add_beat(1, 8'hA1); add_beat(1, 8'hA2); add_beat(1, 8'hA3);
    push_exp(1, 8'hA1); push_exp(1, 8'hA2); push_exp(1, 8'hA3);
    drive();
    tick();
    chk("t1_idle_winc", 32'(obs_winc), 32'd0);
    chk("t1_idle_busy", 32'(obs_busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_winc", 32'(obs_winc), 32'd1);
      chk("t1_gid",  32'(obs_gid),  32'd1);
    end
    tick();
    chk("t1_drop_winc", 32'(obs_winc), 32'd0);
    chk("t1_drop_busy", 32'(obs_busy), 32'd1);
    tick();
    chk("t1_back_idle", 32'(obs_busy), 32'd0);

    // All four requesters continuously valid, five beats each
    do_reset();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 5; k++) add_beat(r, dval(r, k));
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) push_exp(r, dval(r, k));
    for (int r = 0; r < 4; r++) push_exp(r, dval(r, 4));
    drive();
    wcount = 0;
    idles  = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      wcount += int'(obs_winc);
      idles  += int'(!obs_busy);
    end
    chk("t2_writes_in_20", 32'(wcount), 32'd16);
    chk("t2_idle_gaps",    32'(idles),  32'd4);
    wait_drain(200, 1'b0);

    // Requester 2 stalled by wfull after its second beat
    do_reset();
    for (int k = 0; k < 6; k++) begin
      add_beat(2, dval(2, k));
      push_exp(2, dval(2, k));
    end
    drive();
    tick();
    tick();
    tick();
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_stall_winc",  32'(obs_winc),  32'd0);
      chk("t3_stall_ready", 32'(obs_ready), 32'd0);
      chk("t3_stall_gid",   32'(obs_gid),   32'd2);
    end
    chk("t3_stall_busy", 32'(obs_busy), 32'd1);
    wfull = 1'b0;
    tick();
    chk("t3_resume_winc", 32'(obs_winc), 32'd1);
    tick();
    chk("t3_beat4_winc", 32'(obs_winc), 32'd1);
    tick();
    chk("t3_release_after_4", 32'(obs_busy), 32'd0);
    wait_drain(100, 1'b0);

    // Reset in the middle of a burst from requester 3
    do_reset();
    for (int k = 0; k < 4; k++) add_beat(3, dval(3, k));
    push_exp(3, dval(3, 0));
    drive();
    tick();
    tick();
    wrst = 1'b1;
    #1;
    chk("t4_rst_winc",  32'(winc),      32'd0);
    chk("t4_rst_busy",  32'(busy),      32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    flush();
    drive();
    tick();
    tick();
    wrst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      add_beat(r, dval(r, 8));
      push_exp(r, dval(r, 8));
    end
    drive();
    tick();
    chk("t4_arb_idle", 32'(obs_busy), 32'd0);
    tick();
    chk("t4_first_gid",  32'(obs_gid),  32'd0);
    chk("t4_first_winc", 32'(obs_winc), 32'd1);
    wait_drain(100, 1'b0);

    // Requesters 0 and 3: rotation hands over to 3 while 0 still waits
    do_reset();
    for (int k = 0; k < 6; k++) add_beat(0, dval(0, k));
    for (int k = 0; k < 2; k++) add_beat(3, dval(3, k));
    for (int k = 0; k < 4; k++) push_exp(0, dval(0, k));
    for (int k = 0; k < 2; k++) push_exp(3, dval(3, k));
    for (int k = 4; k < 6; k++) push_exp(0, dval(0, k));
    drive();
    wait_drain(100, 1'b0);

    // Same four-way pattern with wfull toggling at random
    do_reset();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 5; k++) add_beat(r, dval(r, k));
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) push_exp(r, dval(r, k));
    for (int r = 0; r < 4; r++) push_exp(r, dval(r, 4));
    drive();
    wait_drain(400, 1'b1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
